rdp_tag_sched: RTL and testbench

Return-data-path tag scheduler. It keeps a small table of outstanding work-unit tags issued by the WU decoder and matches each upstream stack-bus packet to a pending tag. Matched packets are forwarded beat-by-beat onto the NoC data path; after each one, a single completion beat is issued on the NoC control path. Packets whose tags do not match are consumed and dropped, and each drop is counted. The block sits between the WU decoder, the upstream stack-bus controller and the NoC, and it sequences the return data path.

---
 rtl/rdp_tag_sched.sv | 208 ++++++++++++++++++++
 tb/tb_rdp_tag_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdp_tag_sched.sv
// rdp_tag_sched: return-data-path tag scheduler.
// Keeps a small table of outstanding WU tags, matches upstream stack-bus packets
// against it, forwards matched packets to the NoC data path and issues one
// completion beat per packet on the NoC control path. Unmatched packets are dropped
// and counted.
module rdp_tag_sched #(
    parameter int unsigned NUM_TAGS = 4,
    parameter int unsigned TAG_W    = 5,
    parameter int unsigned LANE_W   = 5,
    parameter int unsigned DATA_W   = 64
) (
    input  logic                clk,
    input  logic                reset_poweron_n,
    // WU decoder descriptors
    input  logic                wud__rts__valid,
    output logic                rts__wud__ready,
    input  logic [TAG_W-1:0]    wud__rts__tag,
    input  logic [LANE_W-1:0]   wud__rts__laneId,
    // upstream stack-bus packets
    input  logic                stuc__rts__valid,
    output logic                rts__stuc__ready,
    input  logic [1:0]          stuc__rts__cntl,
    input  logic [TAG_W-1:0]    stuc__rts__tag,
    input  logic [DATA_W-1:0]   stuc__rts__data,
    // NoC data path
    input  logic                noc__rts__dp_ready,
    output logic                rts__noc__dp_valid,
    output logic [1:0]          rts__noc__dp_cntl,
    output logic [LANE_W-1:0]   rts__noc__dp_laneId,
    output logic [DATA_W-1:0]   rts__noc__dp_data,
    // NoC control path (completions)
    input  logic                noc__rts__cp_ready,
    output logic                rts__noc__cp_valid,
    output logic [TAG_W+7:0]    rts__noc__cp_data,
    // error reporting
    output logic                rts__err_unmatched,
    output logic                rts__err_dup,
    output logic [15:0]         rts__unmatched_cnt
);

    localparam int unsigned IDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam int unsigned BCNT_W = 8;
    localparam int unsigned UCNT_W = 16;

    // Stack-bus framing codes (MOM = 2'd1 needs no explicit decode here)
    localparam logic [1:0] CNTL_SOM     = 2'd0;
    localparam logic [1:0] CNTL_EOM     = 2'd2;
    localparam logic [1:0] CNTL_SOM_EOM = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2,
        ST_CMPL = 2'd3
    } state_e;

    state_e                 state_q;
    logic [NUM_TAGS-1:0]    vld_q;
    logic [TAG_W-1:0]       tag_q  [NUM_TAGS];
    logic [LANE_W-1:0]      lane_q [NUM_TAGS];
    logic [IDX_W-1:0]       cur_idx_q;
    logic [LANE_W-1:0]      cur_lane_q;
    logic [BCNT_W-1:0]      beat_cnt_q;
    logic                   err_unmatched_q;
    logic                   err_dup_q;
    logic [UCNT_W-1:0]      unmatched_cnt_q;

    logic                   free_any;
    logic [IDX_W-1:0]       free_idx;
    logic                   dup_hit;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   is_som;
    logic                   desc_xfer;
    logic                   up_xfer;
    logic                   cp_xfer;

    // Table scan: lowest free entry, duplicate check and CAM lookup (lowest hit wins)
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        dup_hit  = 1'b0;
        hit      = 1'b0;
        hit_idx  = '0;
        for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (vld_q[i] && (tag_q[i] == wud__rts__tag)) begin
                dup_hit = 1'b1;
            end
            if (vld_q[i] && (tag_q[i] == stuc__rts__tag)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Handshakes and the combinational stuc-to-dp pass-through
    always_comb begin
        is_som = (stuc__rts__cntl == CNTL_SOM) || (stuc__rts__cntl == CNTL_SOM_EOM);

        rts__stuc__ready = 1'b0;
        unique case (state_q)
            ST_IDLE: rts__stuc__ready = noc__rts__dp_ready;
            ST_FWD:  rts__stuc__ready = noc__rts__dp_ready;
            ST_DROP: rts__stuc__ready = 1'b1;
            default: rts__stuc__ready = 1'b0;
        endcase

        rts__wud__ready    = free_any;
        desc_xfer          = wud__rts__valid && free_any;
        up_xfer            = stuc__rts__valid && rts__stuc__ready;
        cp_xfer            = (state_q == ST_CMPL) && noc__rts__cp_ready;

        rts__noc__dp_valid  = stuc__rts__valid &&
                              ((state_q == ST_FWD) || ((state_q == ST_IDLE) && is_som && hit));
        rts__noc__dp_cntl   = stuc__rts__cntl;
        rts__noc__dp_data   = stuc__rts__data;
        rts__noc__dp_laneId = (state_q == ST_FWD) ? cur_lane_q : lane_q[hit_idx];
    end

    // Table, packet sequencer, error pulses and drop counter
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            state_q         <= ST_IDLE;
            vld_q           <= '0;
            for (int i = 0; i < int'(NUM_TAGS); i++) begin
                tag_q[i]  <= '0;
                lane_q[i] <= '0;
            end
            cur_idx_q       <= '0;
            cur_lane_q      <= '0;
            beat_cnt_q      <= '0;
            err_unmatched_q <= 1'b0;
            err_dup_q       <= 1'b0;
            unmatched_cnt_q <= '0;
        end else begin
            err_unmatched_q <= 1'b0;
            err_dup_q       <= 1'b0;

            // Release of the completed entry; allocation below never targets it
            // because free_idx is derived from the pre-release valid bits.
            if (cp_xfer) begin
                vld_q[cur_idx_q] <= 1'b0;
            end
            if (desc_xfer) begin
                if (dup_hit) begin
                    err_dup_q <= 1'b1;
                end else begin
                    vld_q[free_idx]  <= 1'b1;
                    tag_q[free_idx]  <= wud__rts__tag;
                    lane_q[free_idx] <= wud__rts__laneId;
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                    // Non-header beats here are stray protocol errors and are simply consumed
                    if (up_xfer && is_som) begin
                        if (hit) begin
                            cur_idx_q  <= hit_idx;
                            cur_lane_q <= lane_q[hit_idx];
                            beat_cnt_q <= BCNT_W'(1);
                            state_q    <= (stuc__rts__cntl == CNTL_SOM_EOM) ? ST_CMPL : ST_FWD;
                        end else begin
                            err_unmatched_q <= 1'b1;
                            if (unmatched_cnt_q != {UCNT_W{1'b1}}) begin
                                unmatched_cnt_q <= unmatched_cnt_q + UCNT_W'(1);
                            end
                            if (stuc__rts__cntl == CNTL_SOM) begin
                                state_q <= ST_DROP;
                            end
                        end
                    end
                end
                ST_FWD: begin
                    if (up_xfer) begin
                        if (beat_cnt_q != {BCNT_W{1'b1}}) begin
                            beat_cnt_q <= beat_cnt_q + BCNT_W'(1);
                        end
                        if (stuc__rts__cntl == CNTL_EOM) begin
                            state_q <= ST_CMPL;
                        end
                    end
                end
                ST_DROP: begin
                    if (up_xfer && (stuc__rts__cntl == CNTL_EOM)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    if (cp_xfer) begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign rts__noc__cp_valid = (state_q == ST_CMPL);
    assign rts__noc__cp_data  = {tag_q[cur_idx_q], beat_cnt_q};
    assign rts__err_unmatched = err_unmatched_q;
    assign rts__err_dup       = err_dup_q;
    assign rts__unmatched_cnt = unmatched_cnt_q;

endmodule

// File: tb/tb_rdp_tag_sched.sv
// Bench for rdp_tag_sched: directed scenarios followed by randomized traffic,
// checked against a transaction-level model (set of pending tags -> lane).
module tb_rdp_tag_sched;

    localparam int unsigned NUM_TAGS = 4;
    localparam int unsigned TAG_W    = 5;
    localparam int unsigned LANE_W   = 5;
    localparam int unsigned DATA_W   = 64;

    localparam logic [1:0] SOM     = 2'd0;
    localparam logic [1:0] MOM     = 2'd1;
    localparam logic [1:0] EOM     = 2'd2;
    localparam logic [1:0] SOM_EOM = 2'd3;

    logic                clk = 1'b0;
    logic                reset_poweron_n;
    logic                wud__rts__valid;
    logic                rts__wud__ready;
    logic [TAG_W-1:0]    wud__rts__tag;
    logic [LANE_W-1:0]   wud__rts__laneId;
    logic                stuc__rts__valid;
    logic                rts__stuc__ready;
    logic [1:0]          stuc__rts__cntl;
    logic [TAG_W-1:0]    stuc__rts__tag;
    logic [DATA_W-1:0]   stuc__rts__data;
    logic                noc__rts__dp_ready;
    logic                rts__noc__dp_valid;
    logic [1:0]          rts__noc__dp_cntl;
    logic [LANE_W-1:0]   rts__noc__dp_laneId;
    logic [DATA_W-1:0]   rts__noc__dp_data;
    logic                noc__rts__cp_ready;
    logic                rts__noc__cp_valid;
    logic [TAG_W+7:0]    rts__noc__cp_data;
    logic                rts__err_unmatched;
    logic                rts__err_dup;
    logic [15:0]         rts__unmatched_cnt;

    rdp_tag_sched #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W),
        .LANE_W   (LANE_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk                 (clk),
        .reset_poweron_n     (reset_poweron_n),
        .wud__rts__valid     (wud__rts__valid),
        .rts__wud__ready     (rts__wud__ready),
        .wud__rts__tag       (wud__rts__tag),
        .wud__rts__laneId    (wud__rts__laneId),
        .stuc__rts__valid    (stuc__rts__valid),
        .rts__stuc__ready    (rts__stuc__ready),
        .stuc__rts__cntl     (stuc__rts__cntl),
        .stuc__rts__tag      (stuc__rts__tag),
        .stuc__rts__data     (stuc__rts__data),
        .noc__rts__dp_ready  (noc__rts__dp_ready),
        .rts__noc__dp_valid  (rts__noc__dp_valid),
        .rts__noc__dp_cntl   (rts__noc__dp_cntl),
        .rts__noc__dp_laneId (rts__noc__dp_laneId),
        .rts__noc__dp_data   (rts__noc__dp_data),
        .noc__rts__cp_ready  (noc__rts__cp_ready),
        .rts__noc__cp_valid  (rts__noc__cp_valid),
        .rts__noc__cp_data   (rts__noc__cp_data),
        .rts__err_unmatched  (rts__err_unmatched),
        .rts__err_dup        (rts__err_dup),
        .rts__unmatched_cnt  (rts__unmatched_cnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    bit prev_miss = 1'b0;
    logic [LANE_W-1:0] pend_lane [int];

    // Hard stop in case the DUT never completes a handshake
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer one descriptor for one cycle; it transfers only if the table has room
    task automatic send_desc(input int tag, input int lane);
        bit rdy_exp;
        bit dup_exp;
        rdy_exp = (pend_lane.num() < NUM_TAGS);
        dup_exp = pend_lane.exists(tag);
        wud__rts__valid  = 1'b1;
        wud__rts__tag    = TAG_W'(tag);
        wud__rts__laneId = LANE_W'(lane);
        #1;
        chk("wud_ready", rts__wud__ready, rdy_exp);
        step();
        wud__rts__valid = 1'b0;
        chk("err_dup", rts__err_dup, rdy_exp && dup_exp);
        if (rdy_exp && !dup_exp) pend_lane[tag] = LANE_W'(lane);
        step();
        chk("err_dup_pulse_end", rts__err_dup, 1'b0);
    endtask

    // Send one packet; mode 0 = dp always ready, 1 = toggle, 2 = random.
    // cp_ready is held low for cp_hold cycles of the completion phase.
    task automatic send_pkt(input int tag, input int len, input int mode, input int cp_hold);
        bit hit;
        bit dpr;
        bit rdy_exp;
        bit cpr;
        bit done;
        logic [LANE_W-1:0] lane;
        logic [DATA_W-1:0] d;
        logic [1:0] c;
        logic [63:0] cp_exp;
        int i;
        int cyc;
        int k;
        hit  = pend_lane.exists(tag);
        lane = '0;
        if (hit) lane = pend_lane[tag];
        else exp_cnt++;
        i   = 0;
        cyc = 0;
        d   = {$urandom, $urandom};
        while (i < len) begin
            c = (len == 1) ? SOM_EOM : (i == 0) ? SOM : (i == len - 1) ? EOM : MOM;
            case (mode)
                0:       dpr = 1'b1;
                1:       dpr = ((cyc % 2) == 0);
                default: dpr = 1'($urandom_range(0, 1));
            endcase
            stuc__rts__valid   = 1'b1;
            stuc__rts__cntl    = c;
            stuc__rts__tag     = (i == 0) ? TAG_W'(tag) : TAG_W'($urandom);
            stuc__rts__data    = d;
            noc__rts__dp_ready = dpr;
            #1;
            rdy_exp = (hit || i == 0) ? dpr : 1'b1;
            chk("stuc_ready", rts__stuc__ready, rdy_exp);
            chk("dp_valid", rts__noc__dp_valid, hit);
            if (hit) begin
                chk("dp_data", rts__noc__dp_data, d);
                chk("dp_cntl", rts__noc__dp_cntl, c);
                chk("dp_laneId", rts__noc__dp_laneId, lane);
            end
            chk("cp_valid_during_pkt", rts__noc__cp_valid, 1'b0);
            chk("err_unmatched", rts__err_unmatched, prev_miss);
            prev_miss = (i == 0) && !hit && rdy_exp;
            step();
            cyc++;
            if (rdy_exp) begin
                i++;
                d = {$urandom, $urandom};
            end
        end
        stuc__rts__valid   = 1'b0;
        noc__rts__dp_ready = 1'b1;
        if (hit) begin
            cp_exp = 64'({TAG_W'(tag), 8'((len > 255) ? 255 : len)});
            k    = 0;
            done = 1'b0;
            while (!done) begin
                cpr = (k >= cp_hold) ? ($urandom_range(0, 3) != 0) : 1'b0;
                noc__rts__cp_ready = cpr;
                // A competing header during completion must be held off
                stuc__rts__valid = 1'b1;
                stuc__rts__cntl  = SOM;
                stuc__rts__tag   = TAG_W'(tag);
                #1;
                chk("cp_valid", rts__noc__cp_valid, 1'b1);
                chk("cp_data", rts__noc__cp_data, cp_exp);
                chk("stuc_ready_cmpl", rts__stuc__ready, 1'b0);
                chk("dp_valid_cmpl", rts__noc__dp_valid, 1'b0);
                step();
                k++;
                if (cpr) done = 1'b1;
            end
            pend_lane.delete(tag);
            noc__rts__cp_ready = 1'b0;
            stuc__rts__valid   = 1'b0;
        end
        #1;
        chk("cp_valid_after", rts__noc__cp_valid, 1'b0);
        chk("err_unmatched_tail", rts__err_unmatched, prev_miss);
        chk("wud_ready_after", rts__wud__ready, pend_lane.num() < NUM_TAGS);
        chk("dp_valid_idle", rts__noc__dp_valid, 1'b0);
        prev_miss = 1'b0;
        step();
        chk("unmatched_cnt", rts__unmatched_cnt, 16'(exp_cnt));
        chk("err_unmatched_clear", rts__err_unmatched, 1'b0);
    endtask

    initial begin
        reset_poweron_n    = 1'b0;
        wud__rts__valid    = 1'b0;
        wud__rts__tag      = '0;
        wud__rts__laneId   = '0;
        stuc__rts__valid   = 1'b0;
        stuc__rts__cntl    = SOM;
        stuc__rts__tag     = '0;
        stuc__rts__data    = '0;
        noc__rts__dp_ready = 1'b1;
        noc__rts__cp_ready = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_wud_ready", rts__wud__ready, 1'b1);
        chk("rst_dp_valid", rts__noc__dp_valid, 1'b0);
        chk("rst_cp_valid", rts__noc__cp_valid, 1'b0);
        chk("rst_err_unmatched", rts__err_unmatched, 1'b0);
        chk("rst_err_dup", rts__err_dup, 1'b0);
        chk("rst_unmatched_cnt", rts__unmatched_cnt, 16'd0);
        chk("rst_stuc_ready", rts__stuc__ready, 1'b1);
        reset_poweron_n = 1'b1;
        step();
        chk("post_rst_cp_valid", rts__noc__cp_valid, 1'b0);

        // Basic 4-beat forward and completion {3, 4}
        send_desc(3, 7);
        send_pkt(3, 4, 0, 0);

        // Fill the table, free one entry, refill
        for (int t = 1; t <= 4; t++) send_desc(t, 10 + t);
        #1;
        chk("table_full", rts__wud__ready, 1'b0);
        send_pkt(2, 1, 0, 0);
        send_desc(5, 15);
        #1;
        chk("table_full_again", rts__wud__ready, 1'b0);
        send_pkt(1, 3, 2, 1);
        send_pkt(3, 2, 2, 0);
        send_pkt(4, 1, 0, 2);
        send_pkt(5, 3, 0, 0);

        // Unmatched packet, then a normal one
        send_pkt(9, 3, 0, 0);
        send_desc(10, 3);
        send_pkt(10, 2, 0, 0);

        // Duplicate descriptor leaves a single entry
        send_desc(5, 6);
        send_desc(5, 8);
        send_pkt(5, 2, 0, 0);
        send_pkt(5, 1, 0, 0);

        // dp backpressure toggling, cp held off for 10 cycles
        send_desc(6, 1);
        send_pkt(6, 8, 1, 10);

        // Header in the same cycle as its descriptor misses
        wud__rts__valid    = 1'b1;
        wud__rts__tag      = TAG_W'(12);
        wud__rts__laneId   = LANE_W'(9);
        stuc__rts__valid   = 1'b1;
        stuc__rts__cntl    = SOM_EOM;
        stuc__rts__tag     = TAG_W'(12);
        noc__rts__dp_ready = 1'b1;
        #1;
        chk("same_cycle_dp_valid", rts__noc__dp_valid, 1'b0);
        chk("same_cycle_stuc_ready", rts__stuc__ready, 1'b1);
        step();
        wud__rts__valid  = 1'b0;
        stuc__rts__valid = 1'b0;
        pend_lane[12]    = LANE_W'(9);
        exp_cnt++;
        chk("same_cycle_err", rts__err_unmatched, 1'b1);
        step();
        chk("same_cycle_cnt", rts__unmatched_cnt, 16'(exp_cnt));
        send_pkt(12, 3, 2, 0);

        // Beat count saturation
        send_desc(13, 2);
        send_pkt(13, 260, 0, 0);

        // Reset during FWD beat 2
        send_desc(11, 4);
        stuc__rts__valid = 1'b1;
        stuc__rts__cntl  = SOM;
        stuc__rts__tag   = TAG_W'(11);
        stuc__rts__data  = 64'h1111;
        #1;
        chk("mid_rst_beat0", rts__noc__dp_valid, 1'b1);
        step();
        stuc__rts__cntl = MOM;
        #1;
        chk("mid_rst_beat1_lane", rts__noc__dp_laneId, LANE_W'(4));
        step();
        reset_poweron_n = 1'b0;
        #1;
        chk("mid_rst_dp_valid", rts__noc__dp_valid, 1'b0);
        chk("mid_rst_cp_valid", rts__noc__cp_valid, 1'b0);
        chk("mid_rst_wud_ready", rts__wud__ready, 1'b1);
        chk("mid_rst_err_unmatched", rts__err_unmatched, 1'b0);
        chk("mid_rst_cnt", rts__unmatched_cnt, 16'd0);
        chk("mid_rst_stuc_ready", rts__stuc__ready, 1'b1);
        pend_lane.delete();
        exp_cnt = 0;
        step();
        reset_poweron_n = 1'b1;
        #1;
        chk("post_rst_mom_dp_valid", rts__noc__dp_valid, 1'b0);
        step();
        stuc__rts__cntl = EOM;
        #1;
        chk("post_rst_eom_dp_valid", rts__noc__dp_valid, 1'b0);
        chk("post_rst_mom_err", rts__err_unmatched, 1'b0);
        step();
        stuc__rts__valid = 1'b0;
        #1;
        chk("post_rst_eom_err", rts__err_unmatched, 1'b0);
        chk("post_rst_cnt", rts__unmatched_cnt, 16'd0);
        step();
        send_pkt(11, 1, 0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0)
                send_desc(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
            else
                send_pkt(int'($urandom_range(0, 7)), int'($urandom_range(1, 5)), 2,
                         int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
